// File: rtl/icache_pkg.sv
// -----------------------------------------------------------------------------
// icache_pkg
//   Shared types and constants for the direct-mapped instruction cache.
//   - state_t        : controller states of icache_responder
//   - line geometry  : 64-byte lines, 16 x 32-bit words, 8 x 64-bit bus beats
//   - NOP_INST       : instruction word presented out of reset
//   - READ_TAG       : constant tag placed on every memory read request
//   - line_word()    : selects one 32-bit word from a flattened line
// -----------------------------------------------------------------------------
package icache_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    MISS_REQ,
    FILL,
    RESPOND
  } state_t;

  localparam int LINE_ADDR_W    = 58;
  localparam int LINE_BYTES     = 64;
  localparam int WORD_W         = 32;
  localparam int WORDS_PER_LINE = 16;
  localparam int BEATS_PER_LINE = 8;
  localparam int LINE_W         = WORDS_PER_LINE * WORD_W;

  localparam logic [31:0] NOP_INST = 32'h0100_0000;
  localparam logic [12:0] READ_TAG = 13'h1100;

  // Word 0 sits in the least significant 32 bits of the flattened line.
  function automatic logic [WORD_W-1:0] line_word(input logic [LINE_W-1:0] line,
                                                  input logic [3:0]        sel);
    return line[sel*WORD_W +: WORD_W];
  endfunction

endpackage

// File: rtl/icache_tag_array.sv
// -----------------------------------------------------------------------------
// icache_tag_array
//   Valid bits and tags for the direct-mapped cache, plus the hit compare.
//   The tag RAM has a registered read: rd_idx is presented in the cycle the
//   request is accepted, and the compare against lookup_idx/lookup_tag happens
//   in the following (LOOKUP) cycle. Valid bits are flops so that a flush can
//   clear them all in one cycle; they reset asynchronously.
//
//   clk, reset   : clock, asynchronous active-low reset
//   flush        : clear every valid bit this cycle
//   rd_idx       : index read into the tag output register
//   lookup_idx   : index of the in-flight request
//   lookup_tag   : tag of the in-flight request
//   hit          : valid[lookup_idx] and registered tag equals lookup_tag
//   wr_en        : commit a line (set tag and valid)
//   wr_idx       : index being committed
//   wr_tag       : tag being committed
// -----------------------------------------------------------------------------
module icache_tag_array
  import icache_pkg::*;
#(
  parameter int NUM_SETS = 64,
  parameter int INDEX_W  = $clog2(NUM_SETS),
  parameter int TAG_W    = LINE_ADDR_W - INDEX_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic [INDEX_W-1:0] rd_idx,
  input  logic [INDEX_W-1:0] lookup_idx,
  input  logic [TAG_W-1:0]   lookup_tag,
  output logic               hit,
  input  logic               wr_en,
  input  logic [INDEX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0]   wr_tag
);

  logic [TAG_W-1:0]    tag_mem [NUM_SETS];
  logic [TAG_W-1:0]    tag_rd_reg;
  logic [NUM_SETS-1:0] valid_reg;
  logic [NUM_SETS-1:0] valid_next;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[wr_idx] <= wr_tag;
    end
    tag_rd_reg <= tag_mem[rd_idx];
  end

  // Flush and commit never coincide: flush is only applied while idle.
  for (genvar gi = 0; gi < NUM_SETS; gi++) begin : g_valid
    assign valid_next[gi] = !flush &&
                            (valid_reg[gi] || (wr_en && (wr_idx == INDEX_W'(gi))));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_reg <= '0;
    end else begin
      valid_reg <= valid_next;
    end
  end

  assign hit = valid_reg[lookup_idx] && (tag_rd_reg == lookup_tag);

endmodule

// File: rtl/icache_responder.sv
// -----------------------------------------------------------------------------
// icache_responder
//   Direct-mapped, read-only instruction cache answering the fetch stage.
//   Hits answer two cycles after the request is accepted. Misses issue one
//   line read on the memory port, collect 8 x 64-bit beats into a fill buffer,
//   commit the line, then answer from the fill buffer.
//
//   clk, reset        : clock, asynchronous active-low reset
//   ic_req            : fetch request, held until ic_ack
//   ic_line_addr      : PC[63:6]
//   ic_word_select    : PC[5:2]
//   ic_flush          : invalidate all lines (deferred while busy)
//   ic_ack            : one-cycle pulse, ic_data_out valid
//   ic_data_out       : instruction word, held until the next ack
//   mem_req           : line read request, held until mem_reqack
//   mem_addr          : byte address of the line
//   mem_reqtag        : constant read tag
//   mem_reqack        : request accepted
//   mem_respcyc       : response beat valid
//   mem_resp          : response beat data
//   mem_respack       : beat consumed (only while filling)
// -----------------------------------------------------------------------------
module icache_responder
  import icache_pkg::*;
#(
  parameter int                       NUM_SETS       = 64,
  parameter int                       BUS_DATA_WIDTH = 64,
  parameter int                       BUS_TAG_WIDTH  = 13,
  parameter logic [BUS_TAG_WIDTH-1:0] READ_TAG       = icache_pkg::READ_TAG
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      ic_req,
  input  logic [LINE_ADDR_W-1:0]    ic_line_addr,
  input  logic [3:0]                ic_word_select,
  input  logic                      ic_flush,
  output logic                      ic_ack,
  output logic [WORD_W-1:0]         ic_data_out,
  output logic                      mem_req,
  output logic [63:0]               mem_addr,
  output logic [BUS_TAG_WIDTH-1:0]  mem_reqtag,
  input  logic                      mem_reqack,
  input  logic                      mem_respcyc,
  input  logic [BUS_DATA_WIDTH-1:0] mem_resp,
  output logic                      mem_respack
);

  localparam int INDEX_W    = $clog2(NUM_SETS);
  localparam int TAG_W      = LINE_ADDR_W - INDEX_W;
  localparam int OFFSET_W   = $clog2(LINE_BYTES);
  localparam int BEAT_CNT_W = $clog2(BEATS_PER_LINE);

  state_t                  state_reg;
  logic [LINE_ADDR_W-1:0]  line_reg;
  logic [3:0]              word_reg;
  logic [BEAT_CNT_W-1:0]   beat_cnt_reg;
  logic                    flush_pend_reg;
  logic                    ic_ack_reg;
  logic [WORD_W-1:0]       ic_data_reg;
  logic                    mem_req_reg;
  logic [63:0]             mem_addr_reg;

  logic [INDEX_W-1:0]      idx;
  logic [TAG_W-1:0]        tag;
  logic                    hit;
  logic                    beat_fire;
  logic                    last_beat;
  logic                    flush_apply;

  logic [BUS_DATA_WIDTH-1:0] fill_buf_reg [BEATS_PER_LINE];
  logic [LINE_W-1:0]         fill_line;
  logic [LINE_W-1:0]         commit_line;
  logic [LINE_W-1:0]         data_mem [NUM_SETS];
  logic [LINE_W-1:0]         line_rd_reg;

  assign idx = line_reg[INDEX_W-1:0];
  assign tag = line_reg[LINE_ADDR_W-1:INDEX_W];

  assign beat_fire   = (state_reg == FILL) && mem_respcyc;
  assign last_beat   = beat_fire && (beat_cnt_reg == BEAT_CNT_W'(BEATS_PER_LINE - 1));
  // A flush seen while busy waits until the controller is back in IDLE, so an
  // in-flight fill still commits and is then invalidated with everything else.
  assign flush_apply = (state_reg == IDLE) && (ic_flush || flush_pend_reg);

  assign ic_ack      = ic_ack_reg;
  assign ic_data_out = ic_data_reg;
  assign mem_req     = mem_req_reg;
  assign mem_addr    = mem_addr_reg;
  assign mem_reqtag  = READ_TAG;
  assign mem_respack = beat_fire;

  icache_tag_array #(
    .NUM_SETS (NUM_SETS)
  ) u_tags (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush_apply),
    .rd_idx     (ic_line_addr[INDEX_W-1:0]),
    .lookup_idx (idx),
    .lookup_tag (tag),
    .hit        (hit),
    .wr_en      (last_beat),
    .wr_idx     (idx),
    .wr_tag     (tag)
  );

  // fill_line is the buffered line (used in RESPOND); commit_line substitutes
  // the final beat straight from the bus so the array write happens on it.
  for (genvar gi = 0; gi < BEATS_PER_LINE; gi++) begin : g_line
    assign fill_line[gi*BUS_DATA_WIDTH +: BUS_DATA_WIDTH] = fill_buf_reg[gi];
    if (gi == BEATS_PER_LINE - 1) begin : g_last
      assign commit_line[gi*BUS_DATA_WIDTH +: BUS_DATA_WIDTH] = mem_resp;
    end else begin : g_held
      assign commit_line[gi*BUS_DATA_WIDTH +: BUS_DATA_WIDTH] = fill_buf_reg[gi];
    end
  end

  // Data path: no reset needed. The line read is issued from the raw request
  // address every cycle; the value captured on the accept edge is the one
  // consumed in LOOKUP.
  always_ff @(posedge clk) begin
    if (beat_fire) begin
      fill_buf_reg[beat_cnt_reg] <= mem_resp;
    end
    if (last_beat) begin
      data_mem[idx] <= commit_line;
    end
    line_rd_reg <= data_mem[ic_line_addr[INDEX_W-1:0]];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= IDLE;
      line_reg       <= '0;
      word_reg       <= '0;
      beat_cnt_reg   <= '0;
      flush_pend_reg <= 1'b0;
      ic_ack_reg     <= 1'b0;
      ic_data_reg    <= NOP_INST;
      mem_req_reg    <= 1'b0;
      mem_addr_reg   <= '0;
    end else begin
      ic_ack_reg <= 1'b0;

      if ((state_reg != IDLE) && ic_flush) begin
        flush_pend_reg <= 1'b1;
      end else if (flush_apply) begin
        flush_pend_reg <= 1'b0;
      end

      case (state_reg)
        IDLE: begin
          // In the ack cycle the requestor is still dropping ic_req; ignore it.
          if (!flush_apply && ic_req && !ic_ack_reg) begin
            line_reg  <= ic_line_addr;
            word_reg  <= ic_word_select;
            state_reg <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (hit) begin
            ic_data_reg <= line_word(line_rd_reg, word_reg);
            ic_ack_reg  <= 1'b1;
            state_reg   <= IDLE;
          end else begin
            mem_req_reg  <= 1'b1;
            mem_addr_reg <= {line_reg, {OFFSET_W{1'b0}}};
            state_reg    <= MISS_REQ;
          end
        end
        MISS_REQ: begin
          if (mem_reqack) begin
            mem_req_reg  <= 1'b0;
            beat_cnt_reg <= '0;
            state_reg    <= FILL;
          end
        end
        FILL: begin
          if (beat_fire) begin
            beat_cnt_reg <= beat_cnt_reg + BEAT_CNT_W'(1);
            if (last_beat) begin
              state_reg <= RESPOND;
            end
          end
        end
        RESPOND: begin
          ic_data_reg <= line_word(fill_line, word_reg);
          ic_ack_reg  <= 1'b1;
          state_reg   <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_icache_responder.sv
// -----------------------------------------------------------------------------
// tb_icache_responder
//   Drives fetch requests and a memory bus responder, and compares the cache's
//   answers against a line-level model of a direct-mapped cache.
// -----------------------------------------------------------------------------
module tb_icache_responder;

  localparam logic [31:0] NOP  = 32'h0100_0000;
  localparam logic [12:0] RTAG = 13'h1100;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ic_req = 1'b0;
  logic [57:0] ic_line_addr = '0;
  logic [3:0]  ic_word_select = '0;
  logic        ic_flush = 1'b0;
  logic        ic_ack;
  logic [31:0] ic_data_out;
  logic        mem_req;
  logic [63:0] mem_addr;
  logic [12:0] mem_reqtag;
  logic        mem_reqack = 1'b0;
  logic        mem_respcyc = 1'b0;
  logic [63:0] mem_resp = '0;
  logic        mem_respack;

  always #5 clk = ~clk;

  icache_responder dut (
    .clk            (clk),
    .reset          (reset),
    .ic_req         (ic_req),
    .ic_line_addr   (ic_line_addr),
    .ic_word_select (ic_word_select),
    .ic_flush       (ic_flush),
    .ic_ack         (ic_ack),
    .ic_data_out    (ic_data_out),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_reqtag     (mem_reqtag),
    .mem_reqack     (mem_reqack),
    .mem_respcyc    (mem_respcyc),
    .mem_resp       (mem_resp),
    .mem_respack    (mem_respack)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: one entry per set.
  bit          m_valid [64];
  logic [57:0] m_line  [64];
  logic [31:0] m_word  [64][16];
  logic [63:0] beats   [8];

  // Observations of one fetch transaction.
  bit          obs_miss, obs_addr_stable, obs_req_held, obs_req_dropped, obs_late_req;
  int          obs_lat, obs_acks, obs_respacks, obs_respacks_post;
  logic [31:0] obs_data, obs_held_data, obs_rst_data;
  logic [63:0] obs_addr, obs_rst_addr;
  logic [12:0] obs_tag;
  logic        obs_rst_ack, obs_rst_req, obs_rst_respack;

  task automatic model_flush();
    for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
  endtask

  task automatic model_fill(input logic [57:0] line);
    int idx;
    idx = int'(line[5:0]);
    m_valid[idx] = 1'b1;
    m_line[idx]  = line;
    for (int k = 0; k < 8; k++) begin
      m_word[idx][2*k]   = beats[k][31:0];
      m_word[idx][2*k+1] = beats[k][63:32];
    end
  endtask

  function automatic bit model_hit(input logic [57:0] line);
    int idx;
    idx = int'(line[5:0]);
    return m_valid[idx] && (m_line[idx] == line);
  endfunction

  function automatic logic [31:0] model_word(input logic [57:0] line, input logic [3:0] word);
    return m_word[int'(line[5:0])][int'(word)];
  endfunction

  task automatic random_beats();
    for (int k = 0; k < 8; k++) beats[k] = {$urandom(), $urandom()};
  endtask

  // Runs one request through the DUT, acting as requestor and memory.
  // reset_before = k asserts reset for a cycle before beat k is offered.
  task automatic fetch(input logic [57:0] line, input logic [3:0] word,
                       input int reqack_dly, input int gap, input bit flush_with_req,
                       input int flush_at_beat, input int reset_before);
    int n;
    bit post;
    obs_miss = 0; obs_lat = 0; obs_acks = 0; obs_data = '0;
    obs_respacks = 0; obs_respacks_post = 0; obs_addr = '0; obs_tag = '0;
    obs_addr_stable = 1; obs_req_held = 1; obs_req_dropped = 0; obs_late_req = 0;
    obs_rst_ack = 1'b1; obs_rst_data = '0; obs_rst_req = 1'b1; obs_rst_addr = '1;
    obs_rst_respack = 1'b1;
    post = 0;
    @(negedge clk);
    ic_line_addr = line; ic_word_select = word; ic_req = 1'b1; ic_flush = flush_with_req;
    n = 0;
    while (obs_acks == 0 && !obs_miss && n < 8) begin
      @(negedge clk);
      n++;
      ic_flush = 1'b0;
      // Scramble the address once it has been accepted.
      if (n == (flush_with_req ? 2 : 1)) begin
        ic_line_addr   = 58'({$urandom(), $urandom()});
        ic_word_select = 4'($urandom());
      end
      if (ic_ack) begin
        obs_acks++; obs_data = ic_data_out; obs_lat = n; ic_req = 1'b0;
      end else if (mem_req) begin
        obs_miss = 1; obs_lat = n;
      end
    end
    if (obs_miss) begin
      obs_addr = mem_addr; obs_tag = mem_reqtag;
      for (int d = 0; d < reqack_dly; d++) begin
        @(negedge clk);
        if (!mem_req) obs_req_held = 0;
        if (mem_addr !== obs_addr) obs_addr_stable = 0;
      end
      mem_reqack = 1'b1;
      @(negedge clk);
      mem_reqack = 1'b0;
      obs_req_dropped = !mem_req;
      for (int k = 0; k < 8; k++) begin
        if (k == reset_before) begin
          reset = 1'b0; ic_req = 1'b0; mem_respcyc = 1'b1;
          #1;
          obs_rst_ack = ic_ack; obs_rst_data = ic_data_out; obs_rst_req = mem_req;
          obs_rst_addr = mem_addr; obs_rst_respack = mem_respack;
          @(negedge clk);
          reset = 1'b1; post = 1;
        end
        for (int g = 0; g < gap; g++) begin
          mem_respcyc = 1'b0;
          #1;
          if (mem_respack) begin
            if (post) obs_respacks_post++; else obs_respacks++;
          end
          @(negedge clk);
        end
        mem_respcyc = 1'b1; mem_resp = beats[k];
        if (k == flush_at_beat) ic_flush = 1'b1;
        #1;
        if (mem_respack) begin
          if (post) obs_respacks_post++; else obs_respacks++;
        end
        @(negedge clk);
        ic_flush = 1'b0;
      end
      mem_respcyc = 1'b0;
      n = 0;
      while (obs_acks == 0 && n < 20) begin
        if (ic_ack) begin
          obs_acks++; obs_data = ic_data_out; ic_req = 1'b0;
        end else begin
          @(negedge clk);
          n++;
        end
      end
    end
    ic_req = 1'b0;
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      if (ic_ack) obs_acks++;
      if (mem_req && !obs_miss) obs_late_req = 1;
    end
    obs_held_data = ic_data_out;
    $display("txn line=%h word=%0d miss=%0b lat=%0d acks=%0d respacks=%0d data=%h",
             line, word, obs_miss, obs_lat, obs_acks, obs_respacks, obs_data);
  endtask

  task automatic test_reset();
    reset = 1'b0; mem_respcyc = 1'b1;
    repeat (3) @(negedge clk);
    vectors++; if (ic_ack !== 1'b0) begin miscompares++; $display("FAIL reset_ack: got %b expected 0", ic_ack); end
    vectors++; if (ic_data_out !== NOP) begin miscompares++; $display("FAIL reset_data: got %h expected %h", ic_data_out, NOP); end
    vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL reset_mem_req: got %b expected 0", mem_req); end
    vectors++; if (mem_respack !== 1'b0) begin miscompares++; $display("FAIL reset_respack: got %b expected 0", mem_respack); end
    vectors++; if (mem_addr !== 64'h0) begin miscompares++; $display("FAIL reset_mem_addr: got %h expected 0", mem_addr); end
    vectors++; if (mem_reqtag !== RTAG) begin miscompares++; $display("FAIL reqtag: got %h expected %h", mem_reqtag, RTAG); end
    reset = 1'b1;
    @(negedge clk);
    // Stray beats while idle must be ignored.
    vectors++; if (mem_respack !== 1'b0) begin miscompares++; $display("FAIL idle_respack: got %b expected 0", mem_respack); end
    mem_respcyc = 1'b0;
    model_flush();
    $display("txn reset");
  endtask

  task automatic test_cold_miss();
    for (int i = 0; i < 8; i++) beats[i] = {32'(2*i+1), 32'(2*i)};
    fetch(58'h40, 4'd3, 0, 0, 1'b0, -1, -1);
    model_fill(58'h40);
    vectors++; if (obs_miss !== 1'b1) begin miscompares++; $display("FAIL cold_miss: got %b expected 1", obs_miss); end
    vectors++; if (obs_addr !== 64'h1000) begin miscompares++; $display("FAIL cold_addr: got %h expected 1000", obs_addr); end
    vectors++; if (obs_tag !== RTAG) begin miscompares++; $display("FAIL cold_tag: got %h expected %h", obs_tag, RTAG); end
    vectors++; if (obs_req_dropped !== 1'b1) begin miscompares++; $display("FAIL cold_req_drop: got %b expected 1", obs_req_dropped); end
    vectors++; if (obs_respacks !== 8) begin miscompares++; $display("FAIL cold_respacks: got %0d expected 8", obs_respacks); end
    vectors++; if (obs_acks !== 1) begin miscompares++; $display("FAIL cold_acks: got %0d expected 1", obs_acks); end
    vectors++; if (obs_data !== 32'h3) begin miscompares++; $display("FAIL cold_data: got %h expected 3", obs_data); end
    vectors++; if (obs_held_data !== 32'h3) begin miscompares++; $display("FAIL cold_held: got %h expected 3", obs_held_data); end
  endtask

  task automatic test_hit();
    fetch(58'h40, 4'd14, 0, 0, 1'b0, -1, -1);
    vectors++; if (obs_miss !== 1'b0) begin miscompares++; $display("FAIL hit_miss: got %b expected 0", obs_miss); end
    vectors++; if (obs_late_req !== 1'b0) begin miscompares++; $display("FAIL hit_mem_req: got %b expected 0", obs_late_req); end
    vectors++; if (obs_lat !== 2) begin miscompares++; $display("FAIL hit_latency: got %0d expected 2", obs_lat); end
    vectors++; if (obs_acks !== 1) begin miscompares++; $display("FAIL hit_acks: got %0d expected 1", obs_acks); end
    vectors++; if (obs_data !== 32'hE) begin miscompares++; $display("FAIL hit_data: got %h expected e", obs_data); end
    vectors++; if (obs_held_data !== 32'hE) begin miscompares++; $display("FAIL hit_held: got %h expected e", obs_held_data); end
  endtask

  task automatic test_conflict();
    logic [3:0] w;
    random_beats();
    w = 4'($urandom());
    fetch(58'h80, w, 0, 0, 1'b0, -1, -1);
    model_fill(58'h80);
    vectors++; if (obs_miss !== 1'b1) begin miscompares++; $display("FAIL conflict_miss: got %b expected 1", obs_miss); end
    vectors++; if (obs_addr !== 64'h2000) begin miscompares++; $display("FAIL conflict_addr: got %h expected 2000", obs_addr); end
    vectors++; if (obs_data !== model_word(58'h80, w)) begin miscompares++; $display("FAIL conflict_data: got %h expected %h", obs_data, model_word(58'h80, w)); end
    random_beats();
    w = 4'($urandom());
    fetch(58'h40, w, 0, 0, 1'b0, -1, -1);
    model_fill(58'h40);
    vectors++; if (obs_miss !== 1'b1) begin miscompares++; $display("FAIL conflict_back_miss: got %b expected 1", obs_miss); end
    vectors++; if (obs_data !== model_word(58'h40, w)) begin miscompares++; $display("FAIL conflict_back_data: got %h expected %h", obs_data, model_word(58'h40, w)); end
  endtask

  task automatic test_stall();
    logic [57:0] line;
    logic [3:0]  w;
    line = {52'($urandom_range(4, 100)), 6'($urandom_range(1, 63))};
    w = 4'($urandom());
    random_beats();
    fetch(line, w, 5, 2, 1'b0, -1, -1);
    model_fill(line);
    vectors++; if (obs_miss !== 1'b1) begin miscompares++; $display("FAIL stall_miss: got %b expected 1", obs_miss); end
    vectors++; if (obs_req_held !== 1'b1) begin miscompares++; $display("FAIL stall_req_held: got %b expected 1", obs_req_held); end
    vectors++; if (obs_addr_stable !== 1'b1) begin miscompares++; $display("FAIL stall_addr_stable: got %b expected 1", obs_addr_stable); end
    vectors++; if (obs_addr !== {line, 6'b0}) begin miscompares++; $display("FAIL stall_addr: got %h expected %h", obs_addr, {line, 6'b0}); end
    vectors++; if (obs_respacks !== 8) begin miscompares++; $display("FAIL stall_respacks: got %0d expected 8", obs_respacks); end
    vectors++; if (obs_acks !== 1) begin miscompares++; $display("FAIL stall_acks: got %0d expected 1", obs_acks); end
    vectors++; if (obs_data !== model_word(line, w)) begin miscompares++; $display("FAIL stall_data: got %h expected %h", obs_data, model_word(line, w)); end
  endtask

  task automatic test_reset_mid_fill();
    logic [57:0] line;
    logic [3:0]  w;
    line = 58'h1C5;
    w = 4'($urandom());
    random_beats();
    fetch(line, w, 0, 0, 1'b0, -1, 5);
    model_flush();
    vectors++; if (obs_respacks !== 5) begin miscompares++; $display("FAIL rmf_respacks_pre: got %0d expected 5", obs_respacks); end
    vectors++; if (obs_respacks_post !== 0) begin miscompares++; $display("FAIL rmf_respacks_post: got %0d expected 0", obs_respacks_post); end
    vectors++; if (obs_acks !== 0) begin miscompares++; $display("FAIL rmf_acks: got %0d expected 0", obs_acks); end
    vectors++; if (obs_rst_ack !== 1'b0) begin miscompares++; $display("FAIL rmf_reset_ack: got %b expected 0", obs_rst_ack); end
    vectors++; if (obs_rst_data !== NOP) begin miscompares++; $display("FAIL rmf_reset_data: got %h expected %h", obs_rst_data, NOP); end
    vectors++; if (obs_rst_req !== 1'b0) begin miscompares++; $display("FAIL rmf_reset_req: got %b expected 0", obs_rst_req); end
    vectors++; if (obs_rst_addr !== 64'h0) begin miscompares++; $display("FAIL rmf_reset_addr: got %h expected 0", obs_rst_addr); end
    vectors++; if (obs_rst_respack !== 1'b0) begin miscompares++; $display("FAIL rmf_reset_respack: got %b expected 0", obs_rst_respack); end
    vectors++; if (obs_held_data !== NOP) begin miscompares++; $display("FAIL rmf_held: got %h expected %h", obs_held_data, NOP); end
    random_beats();
    fetch(line, w, 0, 0, 1'b0, -1, -1);
    model_fill(line);
    vectors++; if (obs_miss !== 1'b1) begin miscompares++; $display("FAIL rmf_rerequest_miss: got %b expected 1", obs_miss); end
    vectors++; if (obs_data !== model_word(line, w)) begin miscompares++; $display("FAIL rmf_rerequest_data: got %h expected %h", obs_data, model_word(line, w)); end
  endtask

  task automatic test_flush();
    logic [57:0] line;
    logic [3:0]  w;
    line = 58'h2A7;
    w = 4'($urandom());
    random_beats();
    fetch(line, w, 1, 1, 1'b0, 3, -1);
    model_fill(line);
    vectors++; if (obs_acks !== 1) begin miscompares++; $display("FAIL flush_fill_acks: got %0d expected 1", obs_acks); end
    vectors++; if (obs_data !== model_word(line, w)) begin miscompares++; $display("FAIL flush_fill_data: got %h expected %h", obs_data, model_word(line, w)); end
    model_flush();
    random_beats();
    w = 4'($urandom());
    fetch(line, w, 0, 0, 1'b0, -1, -1);
    model_fill(line);
    vectors++; if (obs_miss !== 1'b1) begin miscompares++; $display("FAIL flush_after_miss: got %b expected 1", obs_miss); end
    vectors++; if (obs_data !== model_word(line, w)) begin miscompares++; $display("FAIL flush_after_data: got %h expected %h", obs_data, model_word(line, w)); end
  endtask

  task automatic test_random();
    logic [57:0] line;
    logic [3:0]  w;
    bit          fl, exp_miss;
    for (int t = 0; t < 30; t++) begin
      line = {52'($urandom_range(1, 3)), 6'($urandom_range(0, 3))};
      w    = 4'($urandom());
      fl   = ($urandom_range(0, 7) == 0);
      random_beats();
      if (fl) model_flush();
      exp_miss = !model_hit(line);
      fetch(line, w, $urandom_range(0, 3), $urandom_range(0, 2), fl, -1, -1);
      if (exp_miss) model_fill(line);
      vectors++; if (obs_miss !== exp_miss) begin miscompares++; $display("FAIL rand_miss[%0d]: got %b expected %b", t, obs_miss, exp_miss); end
      vectors++; if (obs_data !== model_word(line, w)) begin miscompares++; $display("FAIL rand_data[%0d]: got %h expected %h", t, obs_data, model_word(line, w)); end
      vectors++; if (obs_acks !== 1) begin miscompares++; $display("FAIL rand_acks[%0d]: got %0d expected 1", t, obs_acks); end
    end
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_hit();
    test_conflict();
    test_stall();
    test_reset_mid_fill();
    test_flush();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
